// File: rtl/regfile_write_demux_pkg.sv
// Shared constants and holding-stage state encoding for the register-file write demux.
package regfile_write_demux_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/regfile_write_demux_decoder3to8.sv
// Binary-to-one-hot decoder: bit n of onehot_o is set for addr_i == n.
module decoder3to8 (
  input  logic [2:0] addr_i,
  output logic [7:0] onehot_o
);

  // One-hot decode of the 3-bit address
  always_comb begin
    onehot_o = 8'b0000_0000;
    case (addr_i)
      3'd0:    onehot_o = 8'b0000_0001;
      3'd1:    onehot_o = 8'b0000_0010;
      3'd2:    onehot_o = 8'b0000_0100;
      3'd3:    onehot_o = 8'b0000_1000;
      3'd4:    onehot_o = 8'b0001_0000;
      3'd5:    onehot_o = 8'b0010_0000;
      3'd6:    onehot_o = 8'b0100_0000;
      3'd7:    onehot_o = 8'b1000_0000;
      default: onehot_o = 8'b0000_0000;
    endcase
  end

endmodule

// File: rtl/regfile_write_demux.sv
// Eight-entry register file fed through a one-entry write holding stage.
// Optional macro REGFILE_ZERO_REG_EN makes r0 a constant-zero register.
module regfile_write_demux
  import regfile_write_demux_pkg::*;
#(
  parameter int k = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [k-1:0]      wr_data,
  input  logic              hold,
  output logic [7:0]        wr_sel,
  output logic              wr_done,
  output logic [k-1:0]      r0,
  output logic [k-1:0]      r1,
  output logic [k-1:0]      r2,
  output logic [k-1:0]      r3,
  output logic [k-1:0]      r4,
  output logic [k-1:0]      r5,
  output logic [k-1:0]      r6,
  output logic [k-1:0]      r7
);

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [NUM_REGS-1:0] WR_MASK = 8'b1111_1110;
`else
  localparam logic [NUM_REGS-1:0] WR_MASK = 8'b1111_1111;
`endif

  hold_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [k-1:0]        data_q, data_d;
  logic [k-1:0]        reg_q [NUM_REGS];
  logic                done_q;

  logic                ready_s;
  logic                accept_s;
  logic                commit_s;
  logic [NUM_REGS-1:0] dec_s;
  logic [NUM_REGS-1:0] sel_s;
  logic [NUM_REGS-1:0] wr_en_s;

  decoder3to8 u_dec (
    .addr_i   (addr_q),
    .onehot_o (dec_s)
  );

  // Holding-stage next state, handshake and commit decisions
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ready_s  = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      EMPTY: begin
        ready_s  = 1'b1;
        commit_s = 1'b0;
      end
      FULL: begin
        ready_s  = ~hold;
        commit_s = ~hold;
      end
      default: begin
        ready_s  = 1'b0;
        commit_s = 1'b0;
      end
    endcase

    accept_s = wr_valid & ready_s;

    if (accept_s) begin
      state_d = FULL;
      addr_d  = wr_addr;
      data_d  = wr_data;
    end else if (commit_s) begin
      state_d = EMPTY;
    end else begin
      state_d = state_q;
    end

    if (commit_s) begin
      sel_s = dec_s;
    end else begin
      sel_s = 8'b0000_0000;
    end
    // A commit to a hard-wired register still selects it but loads nothing
    wr_en_s = sel_s & WR_MASK;
  end

  // Holding-stage state, entry and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      addr_q  <= 3'd0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= commit_s;
    end
  end

  // Register array load on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_s[i]) begin
          reg_q[i] <= data_q;
        end else begin
          reg_q[i] <= reg_q[i];
        end
      end
    end
  end

  assign wr_ready = ready_s;
  assign wr_sel   = sel_s;
  assign wr_done  = done_q;
  assign r0       = reg_q[0];
  assign r1       = reg_q[1];
  assign r2       = reg_q[2];
  assign r3       = reg_q[3];
  assign r4       = reg_q[4];
  assign r5       = reg_q[5];
  assign r6       = reg_q[6];
  assign r7       = reg_q[7];

endmodule

// File: tb/tb_regfile_write_demux.sv
// Self-checking bench: accepted writes go into a scoreboard queue and are retired against wr_sel/registers.
module tb_regfile_write_demux;

  localparam int K = 16;

  typedef struct packed {
    logic [2:0]   addr;
    logic [K-1:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [2:0]   wr_addr;
  logic [K-1:0] wr_data;
  logic         hold;
  logic [7:0]   wr_sel;
  logic         wr_done;
  logic [K-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [K-1:0] r_obs [8];

  wr_t          sb_q [$];
  logic [K-1:0] m_regs [8];
  logic         m_full;
  logic         m_done;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           done_cnt = 0;
  int           base_cnt;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_write_demux #(.k(K)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .hold     (hold),
    .wr_sel   (wr_sel),
    .wr_done  (wr_done),
    .r0 (r0), .r1 (r1), .r2 (r2), .r3 (r3),
    .r4 (r4), .r5 (r5), .r6 (r6), .r7 (r7)
  );

  assign r_obs[0] = r0; assign r_obs[1] = r1; assign r_obs[2] = r2; assign r_obs[3] = r3;
  assign r_obs[4] = r4; assign r_obs[5] = r5; assign r_obs[6] = r6; assign r_obs[7] = r7;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    logic       exp_ready;
    logic       exp_commit;
    logic       acc;
    logic [7:0] exp_sel;
    wr_t        head;
    if (!rst_n) begin
      sb_q.delete();
      m_full = 1'b0;
      m_done = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
    end
    exp_ready  = !(m_full && hold);
    exp_commit = m_full && !hold && (sb_q.size() != 0);
    exp_sel    = 8'b0;
    if (exp_commit) exp_sel = 8'b1 << sb_q[0].addr;
    check_eq("wr_ready", {31'b0, wr_ready}, {31'b0, exp_ready});
    check_eq("wr_sel", {24'b0, wr_sel}, {24'b0, exp_sel});
    check_eq("wr_done", {31'b0, wr_done}, {31'b0, m_done});
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("r%0d", i), {16'b0, r_obs[i]}, {16'b0, m_regs[i]});
    if (wr_done === 1'b1) done_cnt++;
    if (rst_n) begin
      acc = wr_valid && exp_ready;
      if (exp_commit) begin
        head = sb_q.pop_front();
        if (!(ZERO_REG && head.addr == 3'd0)) m_regs[head.addr] = head.data;
      end
      m_done = exp_commit;
      if (acc) sb_q.push_back({wr_addr, wr_data});
      m_full = acc || (m_full && !exp_commit);
    end
  end

  task automatic drive(input logic v, input logic [2:0] a, input logic [K-1:0] d, input logic h);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    hold     = h;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 16'h0000;
    hold     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset scenario: single write after reset release
    drive(1'b1, 3'd3, 16'h00A5, 1'b0);
    check_eq("sel_after_accept", {24'b0, wr_sel}, 32'h0000_0008);
    idle(3);
    check_eq("r3_first", {16'b0, r3}, 32'h0000_00A5);
    check_eq("r0_untouched", {16'b0, r0}, 32'h0000_0000);

    // Stream scenario: one write per cycle to every address
    base_cnt = done_cnt;
    for (int n = 0; n < 8; n++) begin
      logic [K-1:0] d;
      d = 16'(16'h1111 * (n + 1));
      drive(1'b1, 3'(n), d, 1'b0);
    end
    idle(2);
    check_eq("stream_done_cnt", done_cnt - base_cnt, 32'd8);
    check_eq("stream_r7", {16'b0, r7}, 32'h0000_8888);
    check_eq("stream_r1", {16'b0, r1}, 32'h0000_2222);

    // Stall scenario: hold high for three cycles with a request waiting
    drive(1'b1, 3'd6, 16'h6666, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd1, 16'h0101, 1'b1);
    drive(1'b1, 3'd1, 16'h0101, 1'b0);
    idle(2);
    check_eq("stall_r6", {16'b0, r6}, 32'h0000_6666);
    check_eq("stall_r1", {16'b0, r1}, 32'h0000_0101);

    // Same-address scenario: the later write wins
    drive(1'b1, 3'd5, 16'h1234, 1'b0);
    drive(1'b1, 3'd5, 16'hBEEF, 1'b0);
    idle(2);
    check_eq("same_addr_r5", {16'b0, r5}, 32'h0000_BEEF);

    // Reset with an entry pending: it must be discarded
    drive(1'b1, 3'd2, 16'hFFFF, 1'b0);
    base_cnt = done_cnt;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    hold     = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_ready_empty", {31'b0, wr_ready}, 32'd1);
    idle(2);
    check_eq("rst_r2", {16'b0, r2}, 32'h0000_0000);
    check_eq("rst_no_done", done_cnt - base_cnt, 32'd0);

    // Zero-register scenario
    drive(1'b1, 3'd0, 16'hFFFF, 1'b0);
    check_eq("zero_sel", {24'b0, wr_sel}, 32'h0000_0001);
    idle(2);
    if (ZERO_REG) check_eq("zero_r0", {16'b0, r0}, 32'h0000_0000);
    else          check_eq("zero_r0", {16'b0, r0}, 32'h0000_FFFF);

    // Random traffic with random stalls
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), ($urandom_range(0, 3) == 0));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_demux.md
REGFILE_WRITE_DEMUX -- requirements
Module: regfile_write_demux

Interface
REQ-001 The block SHALL have parameter k, default 16, giving the register and data-bus width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit; it is the single clock, and all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; it is the reset, asynchronous and active-low.
REQ-004 The block SHALL have port wr_valid, input, 1 bit; high means a write request is offered.
REQ-005 The block SHALL have port wr_ready, output, 1 bit; high means the block can accept a request this cycle.
REQ-006 The block SHALL have port wr_addr, input, 3 bits; it is the binary destination register number, 0 to 7.
REQ-007 The block SHALL have port wr_data, input, k bits; it is the write data.
REQ-008 The block SHALL have port hold, input, 1 bit; high stalls the commit stage.
REQ-009 The block SHALL have port wr_sel, output, 8 bits; it is the one-hot load enable of the commit in progress, and all-zero when there is no commit.
REQ-010 The block SHALL have port wr_done, output, 1 bit; it is a one-cycle pulse that is high in the cycle after a commit.
REQ-011 The block SHALL have ports r0 to r7, outputs, k bits each; they are the register contents, presented for the 8:1 read mux.

Function
REQ-012 A request SHALL be accepted on a rising clk edge when wr_valid and wr_ready are both high; wr_addr and wr_data are then captured into a one-entry holding stage.
REQ-013 The holding stage SHALL be a two-state machine.
- EMPTY: transitions to FULL on acceptance.
- FULL: transitions to EMPTY on a commit with no new acceptance; otherwise it stays FULL.
REQ-014 A commit SHALL occur on a rising edge when the state is FULL and hold is low; the held data is then written to the register selected by the held address.
REQ-015 wr_sel SHALL equal the one-hot decode of the held address (bit n for address n) while a commit is enabled, and SHALL be 8'b00000000 otherwise.
REQ-016 wr_ready SHALL be high when the state is EMPTY, or when it is FULL with hold low; it SHALL be low when it is FULL with hold high.
REQ-017 A simultaneous commit and acceptance SHALL do both on the same edge: the old entry is written and the new entry is captured, and the state stays FULL.
REQ-018 Sustained throughput SHALL be one write per cycle while hold is low.
REQ-019 A register SHALL show new data on its rN output one cycle after the commit edge, which is two edges after acceptance.
REQ-020 Back-to-back writes to the same address SHALL be applied in order, so the later data remains.
REQ-021 Registers not selected by wr_sel SHALL hold their value.
REQ-022 wr_done SHALL be registered, and SHALL be high for exactly one cycle after each commit edge.
REQ-023 wr_valid SHALL be ignored while wr_ready is low, and the held entry SHALL then be unchanged.
REQ-024 All outputs SHALL be free of X for any 3-bit wr_addr value.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear the following.
- State goes to EMPTY.
- r0 to r7 go to 0.
- wr_sel goes to 0.
- wr_done goes to 0.
- The holding address and holding data go to 0.
REQ-026 A pending entry at reset assertion SHALL be discarded and not committed.
REQ-027 wr_ready SHALL be high in the first cycle after rst_n deasserts.

Configuration
REQ-028 With macro REGFILE_ZERO_REG_EN defined, r0 SHALL be constant 0: commits to address 0 set wr_sel to 8'b00000001 and pulse wr_done, but leave r0 at 0.
REQ-029 Without REGFILE_ZERO_REG_EN, r0 SHALL be a normal writable register.

Structure
REQ-030 A shared package SHALL hold the following.
- The constants NUM_REGS = 8 and ADDR_W = 3.
- The holding-state enum, with values EMPTY and FULL.
REQ-031 The binary-to-one-hot decode SHALL be a sub-module, decoder3to8, with a 3-bit input and an 8-bit one-hot output.

Verification
REQ-032 Reset scenario: release rst_n, then accept wr_addr=3 with wr_data=16'h00A5 and hold low.
- wr_sel = 8'b00001000 one edge later.
- wr_done high in the cycle after that commit edge.
- r3 = 16'h00A5 two edges after acceptance.
- r3 = 16'h00A5 and all other registers 0 after that.
REQ-033 Stream scenario: send writes to addresses 0 to 7 with data 16'h1111 times (n+1), on consecutive cycles with hold low.
- wr_ready stays high throughout.
- Eight wr_done pulses occur.
- Each rN ends equal to its own data value.
REQ-034 Stall scenario: accept one write, then hold high for 3 cycles while wr_valid stays high.
- wr_ready is low and wr_sel is 0 during the stall.
- The register is unchanged during the stall.
- When hold drops, the write commits and the next request is accepted on the same edge.
REQ-035 Same-address scenario: send two back-to-back writes to address 5, with 16'h1234 then 16'hBEEF.
- r5 = 16'hBEEF at the end.
REQ-036 Reset-mid-operation scenario: accept a write to address 2 with 16'hFFFF, then assert rst_n in the FULL state before the commit.
- r2 = 0.
- No wr_done pulse occurs.
- The state is EMPTY.
REQ-037 Zero-register scenario: with REGFILE_ZERO_REG_EN defined, write 16'hFFFF to address 0.
- wr_sel = 8'b00000001.
- wr_done pulses.
- r0 stays 0.
